// File: rtl/mips32_boot_ctrl.sv
// Boot sequencer for the mips32 core: seeds the register file, streams a program into memory,
// runs the core under a watchdog, then streams a memory result window out.
module mips32_boot_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int REG_INIT = 1,
  parameter int TMO_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        load_base,
  input  logic [ADDR_W-1:0]        load_len,
  input  logic [ADDR_W-1:0]        dump_base,
  input  logic [ADDR_W-1:0]        dump_len,
  input  logic [TMO_W-1:0]         timeout_cyc,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     reg_we,
  output logic [$clog2(NREGS)-1:0] reg_addr,
  output logic [DATA_W-1:0]        reg_wdata,
  output logic                     cpu_run,
  input  logic                     cpu_halted,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_last,
  output logic                     busy,
  output logic                     done,
  output logic                     err_tmo
);
  localparam int RW = $clog2(NREGS);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_RUN, S_DRD, S_DOUT, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   lb_q, lb_d, ll_q, ll_d, db_q, db_d, dl_q, dl_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0]   i_q, i_d, j_q, j_d;
  logic [RW-1:0]       k_q, k_d;
  logic                s_ready_q, s_ready_d, cpu_run_q, cpu_run_d, busy_q, busy_d;
  logic                done_q, done_d, err_q, err_d, reg_we_q, reg_we_d;
  logic [RW-1:0]       reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d, hold_q, hold_d;
  logic                m_valid_q, m_valid_d, m_last_q, m_last_d, first_q, first_d;

  always_comb begin
    state_d = state_q;
    lb_d = lb_q; ll_d = ll_q; db_d = db_q; dl_d = dl_q; tmo_d = tmo_q;
    i_d = i_q; j_d = j_q; k_d = k_q; cnt_d = cnt_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          lb_d = load_base; ll_d = load_len; db_d = dump_base; dl_d = dump_len;
          tmo_d = timeout_cyc;
          i_d = '0; j_d = '0; k_d = '0; cnt_d = '0;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        if (k_q == RW'(NREGS - 1)) state_d = (ll_q == '0) ? S_RUN : S_LOAD;
        else                       k_d = k_q + 1'b1;
      end
      S_LOAD: begin
        if (s_valid) begin
          i_d = i_q + 1'b1;
          if (i_q == ll_q - 1'b1) state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Halt is checked first so a halt on the watchdog's last cycle still dumps.
        if (cpu_halted)                                   state_d = (dl_q == '0) ? S_DONE : S_DRD;
        else if (tmo_q != '0 && cnt_q == tmo_q - 1'b1)   state_d = S_ERR;
        else if (cnt_q != '1)                             cnt_d = cnt_q + 1'b1;
      end
      S_DRD: state_d = S_DOUT;
      S_DOUT: begin
        if (m_ready) begin
          if (j_q == dl_q - 1'b1) state_d = S_DONE;
          else begin
            j_d = j_q + 1'b1;
            state_d = S_DRD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    s_ready_d   = (state_d == S_LOAD);
    cpu_run_d   = (state_d == S_RUN);
    busy_d      = !(state_d inside {S_IDLE, S_DONE, S_ERR});
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
    reg_we_d    = (state_d == S_CLR);
    reg_addr_d  = (state_d == S_CLR) ? k_d : '0;
    reg_wdata_d = (state_d == S_CLR && REG_INIT != 0) ? DATA_W'(k_d) : '0;
    m_valid_d   = (state_d == S_DOUT);
    m_last_d    = (state_d == S_DOUT) && (j_d == dl_q - 1'b1);
    // Read data arrives in the first DOUT cycle; it is bypassed then and held afterwards.
    first_d     = (state_q == S_DRD);
    hold_d      = first_q ? mem_rdata : hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lb_q <= '0; ll_q <= '0; db_q <= '0; dl_q <= '0; tmo_q <= '0;
      i_q <= '0; j_q <= '0; k_q <= '0; cnt_q <= '0;
      s_ready_q <= 1'b0; cpu_run_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
      reg_we_q <= 1'b0; reg_addr_q <= '0; reg_wdata_q <= '0;
      m_valid_q <= 1'b0; m_last_q <= 1'b0; first_q <= 1'b0; hold_q <= '0;
    end else begin
      state_q <= state_d;
      lb_q <= lb_d; ll_q <= ll_d; db_q <= db_d; dl_q <= dl_d; tmo_q <= tmo_d;
      i_q <= i_d; j_q <= j_d; k_q <= k_d; cnt_q <= cnt_d;
      s_ready_q <= s_ready_d; cpu_run_q <= cpu_run_d; busy_q <= busy_d;
      done_q <= done_d; err_q <= err_d;
      reg_we_q <= reg_we_d; reg_addr_q <= reg_addr_d; reg_wdata_q <= reg_wdata_d;
      m_valid_q <= m_valid_d; m_last_q <= m_last_d; first_q <= first_d; hold_q <= hold_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign mem_we    = s_ready_q & s_valid;
  assign mem_addr  = (state_q == S_LOAD) ? lb_q + i_q :
                     (state_q == S_DRD)  ? db_q + j_q : '0;
  assign mem_wdata = mem_we ? s_data : '0;
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign cpu_run   = cpu_run_q;
  assign m_valid   = m_valid_q;
  assign m_data    = first_q ? mem_rdata : hold_q;
  assign m_last    = m_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_tmo   = err_q;
endmodule

// File: tb/tb_mips32_boot_ctrl.sv
// Bench for mips32_boot_ctrl: table of directed jobs plus random jobs, each checked against a
// job-level model (write list, run length, outcome, dump window), and a mid-run reset sequence.
module tb_mips32_boot_ctrl;
  localparam int AW = 10, DW = 32, NR = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start, s_valid, s_ready, mem_we, reg_we, cpu_run, cpu_halted;
  logic          m_valid, m_ready, m_last, busy, done, err_tmo;
  logic [AW-1:0] load_base, load_len, dump_base, dump_len, mem_addr;
  logic [15:0]   timeout_cyc;
  logic [DW-1:0] s_data, mem_wdata, mem_rdata, reg_wdata, m_data;
  logic [4:0]    reg_addr;

  mips32_boot_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_base(load_base), .load_len(load_len),
    .dump_base(dump_base), .dump_len(dump_len), .timeout_cyc(timeout_cyc),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .cpu_run(cpu_run), .cpu_halted(cpu_halted),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .err_tmo(err_tmo)
  );

  // Memory with one-cycle read latency, plus a bench write port used only while the DUT is idle.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] exp_mem [0:1023];
  logic          tb_we;
  logic [AW-1:0] tb_waddr;
  logic [DW-1:0] tb_wdata;
  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_waddr] <= tb_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Stand-in core: raises HALTED in its halt_after-th running cycle (0 = never halts).
  int run_cnt, halt_after;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) run_cnt <= 0;
    else        run_cnt <= cpu_run ? run_cnt + 1 : 0;
  assign cpu_halted = cpu_run && (halt_after != 0) && (run_cnt + 1 >= halt_after);

  typedef struct {
    int lb, ll, db, dl, tmo, halt, vpat, rpat;
    int exp_done, exp_run, exp_ndump;
  } vec_t;

  int errors = 0, checks = 0;
  int o_run, o_regcnt, o_reg_bad, o_stall, o_stab_bad, o_anyv;
  int wa[$];
  logic [DW-1:0] wd[$], dd[$];
  bit dlast[$];
  logic [DW-1:0] prog [0:63];
  logic [DW-1:0] preset [0:15];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".ctrl"}, {s_ready, mem_we, reg_we, cpu_run, m_valid, m_last, busy, done, err_tmo}, 0);
    chk({tag, ".bus"}, |{mem_addr, mem_wdata, reg_addr, reg_wdata, m_data}, 0);
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int idx, it, bad, erun, endn, a;
    bit halted, pst, timed_out;
    logic [DW-1:0] pd;
    logic pl;
    for (int j = 0; j < v.dl; j++) begin
      @(negedge clk);
      a = (v.db + j) % 1024;
      tb_we = 1'b1; tb_waddr = AW'(a); tb_wdata = preset[j];
      exp_mem[a] = preset[j];
    end
    @(negedge clk);
    tb_we = 1'b0;
    for (int i = 0; i < 64; i++) prog[i] = $urandom;
    halt_after = v.halt;
    o_run = 0; o_regcnt = 0; o_reg_bad = 0; o_stall = 0; o_stab_bad = 0; o_anyv = 0;
    wa.delete(); wd.delete(); dd.delete(); dlast.delete();
    idx = 0; it = 0; pst = 0; pd = '0; pl = 0; timed_out = 0;
    load_base = AW'(v.lb); load_len = AW'(v.ll); dump_base = AW'(v.db);
    dump_len = AW'(v.dl); timeout_cyc = 16'(v.tmo); start = 1'b1;
    forever begin
      @(negedge clk);
      if (done || err_tmo) break;
      if (++it > 5000) begin timed_out = 1; break; end
      // Config inputs and start are scrambled while busy; the job must be unaffected.
      start = ($urandom % 6 == 0);
      load_base = AW'($urandom); load_len = AW'($urandom);
      dump_base = AW'($urandom); dump_len = AW'($urandom); timeout_cyc = 16'($urandom);
      case (v.vpat)
        0: s_valid = 1'b1;
        1: s_valid = (it % 2 == 1);
        default: s_valid = ($urandom % 2 == 0);
      endcase
      s_data = prog[idx];
      case (v.rpat)
        0: m_ready = 1'b1;
        3: m_ready = (o_stall >= 10);
        default: m_ready = ($urandom % 3 != 0);
      endcase
      if (s_valid && s_ready) idx++;
      #1;
      if (reg_we) begin
        if (reg_addr != 5'(o_regcnt) || reg_wdata != DW'(o_regcnt)) o_reg_bad++;
        o_regcnt++;
      end
      if (mem_we) begin wa.push_back(int'(mem_addr)); wd.push_back(mem_wdata); end
      if (cpu_run) o_run++;
      if (m_valid) o_anyv = 1;
      if (m_valid && pst && (m_data != pd || m_last != pl)) o_stab_bad++;
      pst = m_valid && !m_ready; pd = m_data; pl = m_last;
      if (pst) o_stall++;
      if (m_valid && m_ready) begin dd.push_back(m_data); dlast.push_back(m_last); end
    end
    start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    chk({tag, ".timeout"}, timed_out, 0);

    // Job-level reference: writes, outcome, run length and dump window.
    chk({tag, ".reg_cnt"}, o_regcnt, NR);
    chk({tag, ".reg_bad"}, o_reg_bad, 0);
    chk({tag, ".wr_cnt"}, wa.size(), v.ll);
    bad = 0;
    for (int i = 0; i < wa.size() && i < v.ll; i++)
      if (wa[i] != (v.lb + i) % 1024 || wd[i] != prog[i]) bad++;
    chk({tag, ".wr_bad"}, bad, 0);
    for (int i = 0; i < v.ll; i++) exp_mem[(v.lb + i) % 1024] = prog[i];
    halted = (v.halt != 0) && (v.tmo == 0 || v.halt <= v.tmo);
    erun = halted ? v.halt : v.tmo;
    chk({tag, ".run_cyc"}, o_run, erun);
    chk({tag, ".done"}, done, halted);
    chk({tag, ".err_tmo"}, err_tmo, !halted);
    chk({tag, ".busy"}, busy, 0);
    endn = halted ? v.dl : 0;
    chk({tag, ".any_mvalid"}, o_anyv, endn != 0);
    chk({tag, ".dump_cnt"}, dd.size(), endn);
    bad = 0;
    for (int j = 0; j < dd.size() && j < endn; j++)
      if (dd[j] != exp_mem[(v.db + j) % 1024] || dlast[j] != (j == v.dl - 1)) bad++;
    chk({tag, ".dump_bad"}, bad, 0);
    chk({tag, ".stable"}, o_stab_bad, 0);
  endtask

  vec_t tbl [7];
  vec_t rv;

  initial begin
    rst_n = 1'b0; start = 0; s_valid = 0; m_ready = 0; s_data = '0;
    load_base = '0; load_len = '0; dump_base = '0; dump_len = '0; timeout_cyc = '0;
    tb_we = 0; tb_waddr = '0; tb_wdata = '0; halt_after = 0;
    for (int a = 0; a < 1024; a++) exp_mem[a] = '0;

    //            lb    ll db   dl tmo halt v  r  done run nd
    tbl[0] = '{   0,   8, 120, 2,  0, 12, 0, 0, 1,  12, 2};
    tbl[1] = '{ 200,   5, 300, 1,  0,  3, 1, 0, 1,   3, 1};
    tbl[2] = '{1022,   4,1022, 4,  0,  5, 2, 1, 1,   5, 4};
    tbl[3] = '{  10,   3, 500, 2, 50,  0, 0, 0, 0,  50, 0};
    tbl[4] = '{  10,   2, 500, 2, 50, 50, 0, 0, 1,  50, 2};
    tbl[5] = '{   0,   0,   0, 0,  0,  1, 0, 0, 1,   1, 0};
    tbl[6] = '{  40,   6,  40, 3, 20,  7, 2, 3, 1,   7, 3};

    repeat (2) @(negedge clk);
    #1 chk_idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 7; t++) begin
      for (int j = 0; j < 16; j++) preset[j] = $urandom;
      if (t == 0) begin preset[0] = 85; preset[1] = 130; end
      run_job(tbl[t], $sformatf("t%0d", t));
      chk($sformatf("t%0d.tbl_done", t), done, tbl[t].exp_done);
      chk($sformatf("t%0d.tbl_run", t), o_run, tbl[t].exp_run);
      chk($sformatf("t%0d.tbl_ndump", t), dd.size(), tbl[t].exp_ndump);
      if (t == 0) begin
        chk("t0.word0", dd.size() >= 2 ? longint'(dd[0]) : -1, 85);
        chk("t0.word1", dd.size() >= 2 ? longint'(dd[1]) : -1, 130);
        chk("t0.last1", dlast.size() >= 2 ? int'(dlast[1]) : -1, 1);
      end
      if (tbl[t].rpat == 3) chk($sformatf("t%0d.stall10", t), o_stall >= 10, 1);
    end

    // Reset while the core is running must drop every output immediately.
    @(negedge clk);
    halt_after = 0;
    load_len = '0; dump_len = '0; timeout_cyc = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && !cpu_run; c++) @(negedge clk);
    chk("rst.run_seen", cpu_run, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_idle_zero("rst_mid_run");
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 15; r++) begin
      rv.lb = $urandom % 1024; rv.ll = $urandom % 24;
      rv.db = $urandom % 1024; rv.dl = $urandom % 9;
      rv.tmo  = ($urandom % 3 == 0) ? 0 : 1 + $urandom % 60;
      rv.halt = ($urandom % 4 == 0) ? 0 : 1 + $urandom % 60;
      if (rv.tmo == 0 && rv.halt == 0) rv.halt = 10;
      rv.vpat = $urandom % 3; rv.rpat = $urandom % 2;
      rv.exp_done = 0; rv.exp_run = 0; rv.exp_ndump = 0;
      for (int j = 0; j < 16; j++) preset[j] = $urandom;
      run_job(rv, $sformatf("r%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
